uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver that feeds the control logic of the flash-bootstrap design from the `rx` pin. It runs on the ~0.994 MHz system clock, synchronises the pin, and deframes 8N1 characters LSB-first using a mid-bit 3-sample majority vote. Each byte is presented on a single-entry valid/ready output buffer, with framing-error and overrun pulses.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per bit (N). 104 gives ≈9558 baud from 0.994 MHz. Legal range 8..65535; elaboration fails outside it.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx` in 1: raw serial pin, asynchronous to `clk`, idle high.
- `data` out 8: received byte, valid while `valid`=1.
- `valid` out 1: output buffer holds an undelivered byte.
- `ready` in 1: consumer accepts `data` when `valid`&`ready`.
- `frame_err` out 1: one-cycle pulse; stop bit sampled 0, byte discarded.
- `overrun` out 1: one-cycle pulse; byte completed while buffer full and not being drained, new byte dropped.

## Operation
- Synchroniser: 2 flops, both reset to 1; output `rx_s`.
- M = N/2 (integer division). `cnt` is a bit-period counter of width clog2(N) that wraps N-1 → 0. `idx` is a 3-bit data-bit index.
- Vote: `rx_s` is stored at cnt=M-1 and cnt=M. At cnt=M+1, vote = majority(stored0, stored1, `rx_s`).
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on `rx_s`=0 → START, cnt←0.
- START: at cnt=M+1, vote=1 means a false start; go to IDLE that cycle. Otherwise, at cnt=N-1 → DATA with idx←0.
- DATA: at cnt=M+1, shreg ← {vote, shreg[7:1]}. At cnt=N-1: if idx=7 → STOP, else idx+1.
- STOP: decides at cnt=M+1, without waiting for the period end.
  - vote=1: deliver shreg and go to IDLE.
  - vote=0: pulse `frame_err`, discard the byte, go to BREAK.
- BREAK: wait for `rx_s`=1, then → IDLE. A held-low line yields exactly one `frame_err` and no spurious starts.
- Delivery: if `valid`=0, or `valid`&`ready` in the same cycle, then `data`←shreg and `valid`←1. Otherwise pulse `overrun` and keep `data`/`valid` unchanged.
- Drain: `valid`&`ready` with no delivery that cycle → `valid`←0. `data` holds its last value.
- `ready` while `valid`=0 has no effect.

## Timing
- Reset values: `data`=8'h00, `valid`=0, `frame_err`=0, `overrun`=0. State IDLE, cnt=0, idx=0, shreg=0, synchroniser flops=1.
- Reset asserted mid-frame aborts the frame with no pulses. After release, a partial frame still on the line is parsed from the next falling `rx_s`.
- Latency: let e0 be the edge at which synchroniser flop 1 first captures the start bit's 0. `valid` rises at e0 + 9N + M + 4, which is 992 cycles for the defaults. `frame_err` and `overrun` pulse in that same cycle in their respective cases.
- Returning to IDLE at mid-stop tolerates ±(M-2)/(10N) baud mismatch. The next start edge is detected without loss.
- Output is registered; no combinational path from `ready` or `rx` to any output.
- Back-to-back frames: one byte per 10N cycles sustained, provided the consumer drains within 10N cycles.

## Structure
- `uart_pkg`: `uart_rx_state_t` enum (IDLE, START, DATA, STOP, BREAK) and `UART_DEFAULT_CLKS_PER_BIT` = 104. The future `uart_tx` shares this package.
- Sub-module `sync2`: generic 2-flop synchroniser with a reset-value parameter (set to 1 here). It is reused for other pin inputs.
- One always_ff for the FSM/counters, one for the output buffer.

## Test plan
- Single frame 0xA5 at N=104, `ready`=1 → `valid` high for 1 cycle at e0+992, `data`=8'hA5, no error pulses.
- Glitch: `rx` low for 30 cycles, then high → START aborts at cnt=M+1, state returns to IDLE, no `valid`, no pulses.
- Stop bit forced 0 on byte 0x3C, line held low 2000 cycles, then high → exactly one `frame_err`, no `valid`. Next frame 0x11 is received correctly.
- Bytes 0x01, 0x02 back-to-back with `ready`=0 → `data` stays 0x01, `overrun` pulses once at the second frame's delivery cycle. Raising `ready` clears `valid`.
- `ready` asserted in exactly the delivery cycle of byte 2 while byte 1 is buffered → `data`=byte 2, `valid` stays 1, no `overrun`.
- Per-bit single-sample glitch at cnt=M on every bit of 0x55 → majority vote yields 0x55. Separately, `rst` pulsed at bit 4 of a frame → all outputs return to reset values immediately, with no pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit period and vote helper.
// The transmitter side imports the same package.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_t;

   localparam int UART_DEFAULT_CLKS_PER_BIT = 104;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for an asynchronous pin; both flops reset to RESET_VAL.
module sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [1:0] stage_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_reg <= {2{RESET_VAL}};
      end else begin
         stage_reg <= {stage_reg[0], d};
      end
   end

   assign q = stage_reg[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit 3-sample majority vote, single-entry valid/ready output
// buffer, one-cycle frame_err and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int N  = CLKS_PER_BIT;
   localparam int M  = N / 2;
   localparam int CW = $clog2(N);

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t CNT_LAST = cnt_t'(N - 1);
   localparam cnt_t CNT_S0   = cnt_t'(M - 1);
   localparam cnt_t CNT_S1   = cnt_t'(M);
   localparam cnt_t CNT_VOTE = cnt_t'(M + 1);

   if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
      $error("uart_rx: CLKS_PER_BIT must be within 8..65535");
   end

   logic rx_s;

   sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   uart_rx_state_t state_reg, state_next;
   cnt_t           cnt_reg, cnt_next;
   logic [2:0]     idx_reg, idx_next;
   logic [7:0]     shreg_reg, shreg_next;
   logic           s0_reg, s0_next;
   logic           s1_reg, s1_next;
   logic           vote;
   logic           deliver;
   logic           ferr;

   assign vote = majority3(s0_reg, s1_reg, rx_s);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         shreg_reg <= '0;
         s0_reg    <= 1'b0;
         s1_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         shreg_reg <= shreg_next;
         s0_reg    <= s0_next;
         s1_reg    <= s1_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + cnt_t'(1);
      idx_next   = idx_reg;
      shreg_next = shreg_reg;
      s0_next    = (cnt_reg == CNT_S0) ? rx_s : s0_reg;
      s1_next    = (cnt_reg == CNT_S1) ? rx_s : s1_reg;
      deliver    = 1'b0;
      ferr       = 1'b0;

      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (!rx_s) state_next = START;
         end
         START: begin
            if (cnt_reg == CNT_VOTE && vote) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = DATA;
               idx_next   = '0;
            end
         end
         DATA: begin
            if (cnt_reg == CNT_VOTE) shreg_next = {vote, shreg_reg[7:1]};
            if (cnt_reg == CNT_LAST) begin
               if (idx_reg == 3'd7) state_next = STOP;
               else                 idx_next   = idx_reg + 3'd1;
            end
         end
         // Decide at mid-stop so the next start edge is never missed under baud mismatch.
         STOP: begin
            if (cnt_reg == CNT_VOTE) begin
               cnt_next = '0;
               if (vote) begin
                  deliver    = 1'b1;
                  state_next = IDLE;
               end else begin
                  ferr       = 1'b1;
                  state_next = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_next = '0;
            if (rx_s) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr;
         overrun   <= 1'b0;
         if (deliver) begin
            if (!valid || ready) begin
               data  <= shreg_reg;
               valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames driven bit by bit, expected events queued by a buffer model,
// a negedge monitor matches every DUT output event (kind, byte, exact cycle).
module tb_uart_rx;

   localparam int N   = 104;
   localparam int M   = N / 2;
   localparam int LAT = 9 * N + M + 4;

   localparam int EV_LOAD = 0;
   localparam int EV_FERR = 1;
   localparam int EV_OVR  = 2;

   typedef struct {
      int kind;
      int data;
      int cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;

   uart_rx #(.CLKS_PER_BIT(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int  vec = 0;
   int  miscompares = 0;
   bit  m_full = 1'b0;
   ev_t exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      vec++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Reference model: the byte lands LAT cycles after the start bit reaches the first flop.
   task automatic push_frame(input logic [7:0] b, input bit stop_ok, input bit rdy_dc, input int t0);
      ev_t e;
      e.cyc  = t0 + 1 + LAT;
      e.data = int'(b);
      if (!stop_ok) begin
         e.kind = EV_FERR;
      end else if (!m_full || rdy_dc) begin
         e.kind = EV_LOAD;
         m_full = 1'b1;
      end else begin
         e.kind = EV_OVR;
      end
      exp_q.push_back(e);
      $display("frame %02h stop=%0d -> expect kind %0d at cycle %0d", b, stop_ok, e.kind, e.cyc);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit glitch,
                             input bit rdy_dc, input bit track);
      logic [9:0] sym;
      logic       v;
      sym = {stop_ok, b, 1'b0};
      for (int s = 0; s < 10; s++) begin
         for (int j = 0; j < N; j++) begin
            tick();
            v = sym[s];
            if (glitch && s >= 1 && s <= 8 && j == M + 1) v = ~v;
            rx = v;
            if (s == 0 && j == 0 && track) push_frame(b, stop_ok, rdy_dc, cyc);
         end
      end
   endtask

   task automatic handle(input int kind, input int d);
      ev_t e;
      vec++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected_event: got kind %0d data 'h%0h at cycle %0d, expected none", kind, d, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc || (kind == EV_LOAD && e.data != d)) begin
            miscompares++;
            $display("FAIL event: got kind %0d data 'h%0h cycle %0d, expected kind %0d data 'h%0h cycle %0d",
                     kind, d, cyc, e.kind, e.data, e.cyc);
         end else begin
            $display("event kind %0d data %02h at cycle %0d ok", kind, d, cyc);
         end
      end
   endtask

   initial begin
      bit  prev_valid = 1'b0;
      bit  prev_ready = 1'b0;
      ev_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
         end else begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               e = exp_q.pop_front();
               vec++;
               miscompares++;
               $display("FAIL missing_event: got nothing by cycle %0d, expected kind %0d data 'h%0h",
                        e.cyc, e.kind, e.data);
            end
            if (valid && (!prev_valid || prev_ready)) handle(EV_LOAD, int'(data));
            if (frame_err) handle(EV_FERR, 0);
            if (overrun)   handle(EV_OVR, 0);
            prev_valid = valid;
            prev_ready = ready;
         end
      end
   end

   initial begin
      int     d2;
      logic [7:0] b;
      bit     ok;

      repeat (3) @(negedge clk);
      check("reset_data", int'(data), 0);
      check("reset_valid", int'(valid), 0);
      check("reset_frame_err", int'(frame_err), 0);
      check("reset_overrun", int'(overrun), 0);
      tick();
      rst = 1'b0;
      idle(5);

      // single frame, consumer always ready
      ready = 1'b1;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(20);
      m_full = 1'b0;

      // 30-cycle glitch must abort in START without any output
      rx = 1'b0;
      idle(30);
      rx = 1'b1;
      idle(200);

      // bad stop bit, line held low, then a clean frame
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(2000);
      rx = 1'b1;
      idle(10);
      send_frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(20);
      m_full = 1'b0;

      // overrun: two frames back to back with nobody draining
      ready = 1'b0;
      send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
      send_frame(8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(20);
      @(negedge clk);
      check("overrun_data_kept", int'(data), 'h01);
      check("overrun_valid_kept", int'(valid), 1);
      tick();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      @(negedge clk);
      check("drain_clears_valid", int'(valid), 0);
      check("drain_keeps_data", int'(data), 'h01);
      tick();
      m_full = 1'b0;

      // ready exactly in the delivery cycle of the second byte
      send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(20);
      d2 = cyc + 2 + LAT;
      fork
         send_frame(8'h3A, 1'b1, 1'b0, 1'b1, 1'b1);
         begin
            while (cyc < d2 - 1) tick();
            ready = 1'b1;
            tick();
            ready = 1'b0;
         end
      join
      idle(20);
      @(negedge clk);
      check("same_cycle_data", int'(data), 'h3A);
      check("same_cycle_valid", int'(valid), 1);
      tick();
      ready = 1'b1;
      tick();
      m_full = 1'b0;

      // single-sample glitch at the middle sample of every data bit
      send_frame(8'h55, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(20);
      m_full = 1'b0;

      // reset mid-frame, with a byte sitting in the buffer
      ready = 1'b0;
      send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(20);
      @(negedge clk);
      check("prereset_data", int'(data), 'h96);
      tick();
      fork
         send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
         begin
            idle(5 * N + M);
            rst = 1'b1;
            @(negedge clk);
            check("midreset_data", int'(data), 0);
            check("midreset_valid", int'(valid), 0);
            check("midreset_frame_err", int'(frame_err), 0);
            check("midreset_overrun", int'(overrun), 0);
            tick();
            tick();
            rst = 1'b0;
         end
      join
      idle(50);
      m_full = 1'b0;
      ready = 1'b1;

      // randomized bytes with occasional framing errors
      repeat (12) begin
         b  = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 4) != 0);
         send_frame(b, ok, 1'b0, 1'b1, 1'b1);
         if (!ok) begin
            idle($urandom_range(0, 2 * N));
            rx = 1'b1;
         end
         idle($urandom_range(2, 40));
         m_full = 1'b0;
      end

      idle(50);
      check("pending_events", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
      $finish;
   end

endmodule
